// File: rtl/cache_array_assoc_if.sv
// Bus between the cache controller and the set-associative array:
// lookup, entry write, flush control and dirty-line writeback.
interface cache_array_assoc_if #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 27,
  parameter int DATA_W   = 32
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic              lk_req;
  logic [IDX_W-1:0]  lk_index;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_rsp;
  logic              lk_hit;
  logic [WAY_W-1:0]  lk_hit_way;
  logic [DATA_W-1:0] lk_hit_data;
  logic [WAY_W-1:0]  lk_vic_way;
  logic              lk_vic_valid;
  logic              lk_vic_dirty;
  logic [TAG_W-1:0]  lk_vic_tag;
  logic [DATA_W-1:0] lk_vic_data;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [WAY_W-1:0]  wr_way;
  logic              wr_valid;
  logic              wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  logic              flush_start;
  logic              busy;
  logic              flush_done;

  logic              wb_valid;
  logic              wb_ready;
  logic [IDX_W-1:0]  wb_index;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output lk_req, lk_index, lk_tag,
    input  lk_rsp, lk_hit, lk_hit_way, lk_hit_data,
    input  lk_vic_way, lk_vic_valid, lk_vic_dirty,
    input  lk_vic_tag, lk_vic_data,
    output wr_en, wr_index, wr_way, wr_valid,
    output wr_dirty, wr_tag, wr_data,
    output flush_start,
    input  busy, flush_done,
    input  wb_valid, wb_index, wb_tag, wb_data,
    output wb_ready
  );

  modport slave (
    input  lk_req, lk_index, lk_tag,
    output lk_rsp, lk_hit, lk_hit_way, lk_hit_data,
    output lk_vic_way, lk_vic_valid, lk_vic_dirty,
    output lk_vic_tag, lk_vic_data,
    input  wr_en, wr_index, wr_way, wr_valid,
    input  wr_dirty, wr_tag, wr_data,
    input  flush_start,
    output busy, flush_done,
    output wb_valid, wb_index, wb_tag, wb_data,
    input  wb_ready
  );
endinterface

// File: rtl/cache_array_assoc.sv
// N-way set-associative tag/data store with true-LRU replacement,
// registered lookup and a dirty-line flush engine.
module cache_array_assoc #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 27,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_array_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int PTR_W = IDX_W + WAY_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } state_t;

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  state_t                            state_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data_q [NUM_SETS][NUM_WAYS];
  ages_t             age_q  [NUM_SETS];
  ages_t             ages_d [NUM_SETS];

  logic [PTR_W-1:0]  ptr_q;
  logic              busy_q;
  logic              done_q;
  logic              wb_valid_q;
  logic [IDX_W-1:0]  wb_index_q;
  logic [TAG_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              lk_rsp_q;
  logic              lk_hit_q;
  logic [WAY_W-1:0]  lk_hit_way_q;
  logic [DATA_W-1:0] lk_hit_data_q;
  logic [WAY_W-1:0]  lk_vic_way_q;
  logic              lk_vic_valid_q;
  logic              lk_vic_dirty_q;
  logic [TAG_W-1:0]  lk_vic_tag_q;
  logic [DATA_W-1:0] lk_vic_data_q;

  logic              lk_go;
  logic              wr_go;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  ages_t             vic_ages;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  vic_way;
  logic [IDX_W-1:0]  ptr_set;
  logic [WAY_W-1:0]  ptr_way;
  logic              ent_dirty;
  logic              step;

  function automatic ages_t touch(ages_t a, logic [WAY_W-1:0] t);
    ages_t r;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == t)
        r[w] = '0;
      else if (a[w] < a[t])
        r[w] = a[w] + 1'b1;
      else
        r[w] = a[w];
    end
    return r;
  endfunction

  function automatic ages_t age_init();
    ages_t r;
    for (int w = 0; w < NUM_WAYS; w++)
      r[w] = WAY_W'(w);
    return r;
  endfunction

  assign lk_go   = bus.lk_req && !busy_q;
  assign wr_go   = bus.wr_en && !busy_q;
  assign ptr_set = ptr_q[PTR_W-1:WAY_W];
  assign ptr_way = ptr_q[WAY_W-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[bus.lk_index][w] &&
          tag_q[bus.lk_index][w] == bus.lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim is chosen as if this lookup's own hit touch has already landed.
  always_comb begin
    vic_ages  = age_q[bus.lk_index];
    if (hit)
      vic_ages = touch(age_q[bus.lk_index], hit_way);
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[bus.lk_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (vic_ages[w] == WAY_W'(NUM_WAYS - 1))
        lru_way = WAY_W'(w);
    end
    vic_way = inv_found ? inv_way : lru_way;
  end

  // Hit touch first, then the write touch, so the write ends up MRU.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      ages_d[s] = age_q[s];
      if (lk_go && hit && bus.lk_index == IDX_W'(s))
        ages_d[s] = touch(ages_d[s], hit_way);
      if (wr_go && bus.wr_valid && bus.wr_index == IDX_W'(s))
        ages_d[s] = touch(ages_d[s], bus.wr_way);
    end
  end

  always_comb begin
    ent_dirty = valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way];
    step      = (state_q == SCAN && !ent_dirty) ||
                (state_q == WB && bus.wb_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      ptr_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_index_q     <= '0;
      wb_tag_q       <= '0;
      wb_data_q      <= '0;
      lk_rsp_q       <= 1'b0;
      lk_hit_q       <= 1'b0;
      lk_hit_way_q   <= '0;
      lk_hit_data_q  <= '0;
      lk_vic_way_q   <= '0;
      lk_vic_valid_q <= 1'b0;
      lk_vic_dirty_q <= 1'b0;
      lk_vic_tag_q   <= '0;
      lk_vic_data_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        age_q[s] <= age_init();
        for (int w = 0; w < NUM_WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      lk_rsp_q <= lk_go;
      done_q   <= 1'b0;
      if (lk_go) begin
        lk_hit_q       <= hit;
        lk_hit_way_q   <= hit_way;
        lk_hit_data_q  <= hit ? data_q[bus.lk_index][hit_way] : '0;
        lk_vic_way_q   <= vic_way;
        lk_vic_valid_q <= valid_q[bus.lk_index][vic_way];
        lk_vic_dirty_q <= dirty_q[bus.lk_index][vic_way];
        lk_vic_tag_q   <= tag_q[bus.lk_index][vic_way];
        lk_vic_data_q  <= data_q[bus.lk_index][vic_way];
      end
      for (int s = 0; s < NUM_SETS; s++)
        age_q[s] <= ages_d[s];
      if (wr_go) begin
        valid_q[bus.wr_index][bus.wr_way] <= bus.wr_valid;
        dirty_q[bus.wr_index][bus.wr_way] <= bus.wr_valid & bus.wr_dirty;
        tag_q[bus.wr_index][bus.wr_way]   <= bus.wr_tag;
        data_q[bus.wr_index][bus.wr_way]  <= bus.wr_data;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.flush_start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        SCAN: begin
          if (ent_dirty) begin
            state_q    <= WB;
            wb_valid_q <= 1'b1;
            wb_index_q <= ptr_set;
            wb_tag_q   <= tag_q[ptr_set][ptr_way];
            wb_data_q  <= data_q[ptr_set][ptr_way];
          end
        end
        WB: begin
          if (bus.wb_ready)
            wb_valid_q <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
      if (step) begin
        valid_q[ptr_set][ptr_way] <= 1'b0;
        dirty_q[ptr_set][ptr_way] <= 1'b0;
        if (&ptr_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          for (int s = 0; s < NUM_SETS; s++)
            age_q[s] <= age_init();
        end else begin
          state_q <= SCAN;
          ptr_q   <= ptr_q + 1'b1;
        end
      end
    end
  end

  assign bus.lk_rsp       = lk_rsp_q;
  assign bus.lk_hit       = lk_hit_q;
  assign bus.lk_hit_way   = lk_hit_way_q;
  assign bus.lk_hit_data  = lk_hit_data_q;
  assign bus.lk_vic_way   = lk_vic_way_q;
  assign bus.lk_vic_valid = lk_vic_valid_q;
  assign bus.lk_vic_dirty = lk_vic_dirty_q;
  assign bus.lk_vic_tag   = lk_vic_tag_q;
  assign bus.lk_vic_data  = lk_vic_data_q;
  assign bus.busy         = busy_q;
  assign bus.flush_done   = done_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_index     = wb_index_q;
  assign bus.wb_tag       = wb_tag_q;
  assign bus.wb_data      = wb_data_q;
endmodule

// File: tb/tb_cache_array_assoc.sv
// Directed bench for cache_array_assoc: lookup results go through a
// queue scoreboard; flush and writeback are checked in line.
module tb_cache_array_assoc;
  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic [31:0] data;
    logic [1:0]  vway;
    logic        vvalid;
    logic        vdirty;
    logic [26:0] vtag;
    logic [31:0] vdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sb [$];

  cache_array_assoc_if bif ();

  cache_array_assoc dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && bif.flush_done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bif.lk_rsp) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        check("lk_hit", 64'(bif.lk_hit), 64'(e.hit));
        check("lk_hit_way", 64'(bif.lk_hit_way), 64'(e.way));
        check("lk_hit_data", 64'(bif.lk_hit_data), 64'(e.data));
        check("lk_vic_way", 64'(bif.lk_vic_way), 64'(e.vway));
        check("lk_vic_valid", 64'(bif.lk_vic_valid), 64'(e.vvalid));
        check("lk_vic_dirty", 64'(bif.lk_vic_dirty), 64'(e.vdirty));
        check("lk_vic_tag", 64'(bif.lk_vic_tag), 64'(e.vtag));
        check("lk_vic_data", 64'(bif.lk_vic_data), 64'(e.vdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input int idx, input logic [26:0] tag,
                    input logic hit, input logic [1:0] way,
                    input logic [31:0] data, input logic [1:0] vway,
                    input logic vvalid, input logic vdirty,
                    input logic [26:0] vtag, input logic [31:0] vdata);
    exp_t e;
    e = '{hit, way, data, vway, vvalid, vdirty, vtag, vdata, cyc + 1};
    sb.push_back(e);
    bif.lk_req   = 1'b1;
    bif.lk_index = 3'(idx);
    bif.lk_tag   = tag;
    tick();
    bif.lk_req = 1'b0;
  endtask

  task automatic wr_drive(input int idx, input int way, input logic v,
                          input logic d, input logic [26:0] tag,
                          input logic [31:0] data);
    bif.wr_en    = 1'b1;
    bif.wr_index = 3'(idx);
    bif.wr_way   = 2'(way);
    bif.wr_valid = v;
    bif.wr_dirty = d;
    bif.wr_tag   = tag;
    bif.wr_data  = data;
  endtask

  task automatic wr(input int idx, input int way, input logic v,
                    input logic d, input logic [26:0] tag,
                    input logic [31:0] data);
    wr_drive(idx, way, v, d, tag, data);
    tick();
    bif.wr_en = 1'b0;
  endtask

  initial begin
    int n;
    int dc;
    cyc = 0; checks = 0; errors = 0; done_cnt = 0;
    rst = 1'b1;
    bif.lk_req = 1'b0; bif.lk_index = '0; bif.lk_tag = '0;
    bif.wr_en = 1'b0; bif.wr_index = '0; bif.wr_way = '0;
    bif.wr_valid = 1'b0; bif.wr_dirty = 1'b0;
    bif.wr_tag = '0; bif.wr_data = '0;
    bif.flush_start = 1'b0; bif.wb_ready = 1'b0;
    #3;
    check("rst_lk_rsp", 64'(bif.lk_rsp), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_flush_done", 64'(bif.flush_done), 64'd0);
    check("rst_wb_valid", 64'(bif.wb_valid), 64'd0);
    check("rst_lk_vic_tag", 64'(bif.lk_vic_tag), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    lk(3, 27'h5, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    wr(2, 1, 1, 0, 27'h1AB, 32'hDEADBEEF);
    lk(2, 27'h1AB, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    check("hold_hit_data", 64'(bif.lk_hit_data), 64'hDEADBEEF);
    check("hold_rsp_low", 64'(bif.lk_rsp), 64'd0);
    wr(2, 1, 0, 0, 27'h1AB, 32'hDEADBEEF);
    lk(2, 27'h1AB, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int w = 0; w < 4; w++)
      wr(0, w, 1, 0, 27'(32'h10 + w), 32'h100 + w);
    lk(0, 27'h10, 1, 0, 32'h100, 1, 1, 0, 27'h11, 32'h101);
    lk(0, 27'h11, 1, 1, 32'h101, 2, 1, 0, 27'h12, 32'h102);

    wr_drive(5, 0, 1, 0, 27'h7, 32'h77);
    lk(5, 27'h7, 0, 0, 0, 0, 0, 0, 0, 0);
    bif.wr_en = 1'b0;
    lk(5, 27'h7, 1, 0, 32'h77, 1, 0, 0, 0, 0);
    tick();

    wr(1, 2, 1, 1, 27'h222, 32'hAAAA0001);
    wr(6, 0, 1, 1, 27'h666, 32'hBBBB0006);
    lk(1, 27'h222, 1, 2, 32'hAAAA0001, 0, 0, 0, 0, 0);
    tick();

    dc = done_cnt;
    bif.flush_start = 1'b1;
    tick();
    bif.flush_start = 1'b0;
    check("busy_after_start", 64'(bif.busy), 64'd1);
    n = 0;
    while (!bif.wb_valid && n < 200) begin tick(); n++; end
    check("wb1_valid", 64'(bif.wb_valid), 64'd1);
    check("wb1_index", 64'(bif.wb_index), 64'd1);
    check("wb1_tag", 64'(bif.wb_tag), 64'h222);
    check("wb1_data", 64'(bif.wb_data), 64'hAAAA0001);
    bif.lk_req = 1'b1;
    bif.lk_index = 3'd0;
    bif.lk_tag = 27'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wb1_hold_valid", 64'(bif.wb_valid), 64'd1);
      check("wb1_hold_index", 64'(bif.wb_index), 64'd1);
      check("wb1_hold_tag", 64'(bif.wb_tag), 64'h222);
      check("wb1_hold_data", 64'(bif.wb_data), 64'hAAAA0001);
      check("busy_lk_rsp", 64'(bif.lk_rsp), 64'd0);
    end
    bif.lk_req = 1'b0;
    bif.wb_ready = 1'b1;
    tick();
    n = 0;
    while (!bif.wb_valid && n < 200) begin tick(); n++; end
    check("wb2_valid", 64'(bif.wb_valid), 64'd1);
    check("wb2_index", 64'(bif.wb_index), 64'd6);
    check("wb2_tag", 64'(bif.wb_tag), 64'h666);
    check("wb2_data", 64'(bif.wb_data), 64'hBBBB0006);
    n = 0;
    while (bif.busy && n < 200) begin tick(); n++; end
    check("busy_cleared", 64'(bif.busy), 64'd0);
    repeat (4) tick();
    bif.wb_ready = 1'b0;
    check("flush_done_once", 64'(done_cnt - dc), 64'd1);

    lk(0, 27'h10, 0, 0, 0, 0, 0, 0, 27'h10, 32'h100);
    lk(2, 27'h1AB, 0, 0, 0, 0, 0, 0, 0, 0);
    lk(1, 27'h222, 0, 0, 0, 0, 0, 0, 0, 0);
    lk(6, 27'h666, 0, 0, 0, 0, 0, 0, 27'h666, 32'hBBBB0006);
    lk(5, 27'h7, 0, 0, 0, 0, 0, 0, 27'h7, 32'h77);
    tick();

    wr(3, 1, 1, 1, 27'h333, 32'h3333);
    dc = done_cnt;
    bif.flush_start = 1'b1;
    tick();
    bif.flush_start = 1'b0;
    n = 0;
    while (!bif.wb_valid && n < 200) begin tick(); n++; end
    check("wb3_valid", 64'(bif.wb_valid), 64'd1);
    check("wb3_index", 64'(bif.wb_index), 64'd3);
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bif.busy), 64'd0);
    check("abort_wb_valid", 64'(bif.wb_valid), 64'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    lk(3, 27'h333, 0, 0, 0, 0, 0, 0, 0, 0);
    lk(0, 27'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_array_assoc.md
Name: cache_array_assoc

Overview:
- Parametrised N-way set-associative tag/data/valid/dirty store; next generation of the 2-way, 4-set cache array.
- Adds per-set true-LRU replacement and a registered lookup with tag compare.
- Adds a flush engine that writes back dirty lines over a ready/valid port, then invalidates.
- Sits between the cache controller FSM and the memory-side writeback path.

Parameters:
- NUM_SETS, 8, number of sets; power of 2, >=2; IDX_W = clog2(NUM_SETS).
- NUM_WAYS, 4, associativity; power of 2, >=2; WAY_W = clog2(NUM_WAYS).
- TAG_W, 27, tag width.
- DATA_W, 32, line data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- lk_req  in  1  lookup request.
- lk_index  in  IDX_W  lookup set.
- lk_tag  in  TAG_W  lookup tag.
- lk_rsp  out  1  lookup result valid; one-cycle pulse.
- lk_hit  out  1  tag match on a valid way.
- lk_hit_way  out  WAY_W  matching way; 0 on miss.
- lk_hit_data  out  DATA_W  data of matching way; 0 on miss.
- lk_vic_way  out  WAY_W  replacement way.
- lk_vic_valid, lk_vic_dirty  out  1 each  state of the victim way.
- lk_vic_tag  out  TAG_W  tag of the victim way.
- lk_vic_data  out  DATA_W  data of the victim way.
- wr_en  in  1  write one entry.
- wr_index  in  IDX_W  set to write.
- wr_way  in  WAY_W  way to write.
- wr_valid, wr_dirty  in  1 each  valid and dirty bits to store.
- wr_tag  in  TAG_W  tag to store.
- wr_data  in  DATA_W  data to store.
- flush_start  in  1  start flush; sampled in IDLE only.
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse at end of flush.
- wb_valid  out  1  dirty line offered for writeback.
- wb_ready  in  1  writeback accepted.
- wb_index  out  IDX_W  set of the offered line.
- wb_tag  out  TAG_W  tag of the offered line.
- wb_data  out  DATA_W  data of the offered line.

Behaviour:
- Reset (async): all valid, dirty, tag and data cleared. LRU age of way w in every set = w. FSM to IDLE. All outputs 0.
- LRU: per-set ages form a permutation of 0..NUM_WAYS-1; 0 = MRU.
- Touching way t sets age[t] = 0 and increments every age < old age[t].
- A touch occurs on a lookup hit (at response edge) or on wr_en with wr_valid=1.
- If lookup hit and write target the same set in one cycle, the write's touch is applied last.
- Victim = lowest-index invalid way; else the way with age NUM_WAYS-1.
- Lookup: lk_req in cycle N -> lk_rsp=1 in cycle N+1, all lk_* outputs registered.
- Compare uses array state before any same-cycle write (read-before-write; no bypass).
- Multiple tag matches in one set are illegal; the lowest matching way wins.
- lk_* data outputs hold their value until the next lk_rsp.
- Write: takes effect at the rising edge; visible to a lookup issued the following cycle.
- wr_valid=0 invalidates the entry and does not touch LRU.
- FSM IDLE: lookups and writes serviced; flush_start=1 -> SCAN with ptr = {set 0, way 0}, busy=1 from the next cycle.
- FSM SCAN: examines the entry at ptr.
  - Valid and dirty -> WB.
  - Otherwise clear valid/dirty, advance ptr (way first, then set), one entry per cycle.
  - Last entry (NUM_SETS-1, NUM_WAYS-1) processed -> DONE.
- FSM WB: wb_valid=1 with wb_index/wb_tag/wb_data stable until wb_ready.
  - On the wb_valid && wb_ready edge: clear valid/dirty, advance ptr, return to SCAN (or DONE if last).
- FSM DONE: flush_done=1 for one cycle; LRU ages reset to w in all sets; busy=0; -> IDLE.
- While busy: lk_req, wr_en and flush_start are ignored; lk_rsp stays 0.
- A lookup issued in the cycle flush_start is accepted still completes normally.
- Reset mid-flush aborts immediately; no flush_done is issued.

Test Plan:
- Reset, then lookup set 3 tag 0x5 -> lk_rsp next cycle, lk_hit=0, lk_vic_way=0, lk_vic_valid=0.
- Write set 2 way 1 tag 0x1AB data 0xDEADBEEF valid, then lookup set 2 tag 0x1AB -> hit, way 1, data 0xDEADBEEF.
- Fill set 0 ways 0..3 in order, then lookup-hit way 0 -> lk_vic_way=1; then touch way 1 -> victim becomes way 2.
- Same-cycle write set 5 way 0 tag 0x7 and lookup set 5 tag 0x7 on an empty array -> lk_hit=0; repeat lookup next cycle -> lk_hit=1.
- Dirty lines at (1,2) and (6,0), flush with wb_ready held 0 for 3 cycles -> wb_valid held with index 1, tag and data stable.
  - Raise wb_ready -> second writeback is index 6.
  - flush_done pulses once; all lookups then miss.
- Assert rst during WB -> busy=0, wb_valid=0, all entries invalid, no flush_done.
